alu_secuenciador: RTL

- Issuer-side controller for the combinational ALU. Drives the ALU's ALUA/ALUB/ALUFlagIn/ALUControl inputs and consumes ALUResult/ALUFlags/ALUZero.
- Holds a small operand register file plus carry (C) and zero (Z) flag registers.
- Accepts one command at a time through a valid/ready handshake, executes it through the external ALU, writes the result back and pulses done.
- Sits between a host/test sequencer and one ALU instance.

---
 rtl/alu_secuenciador.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_secuenciador.sv
// rtl/alu_secuenciador.sv - issuer-side sequencer for one combinational ALU
//
// Holds NREG operand registers plus stored carry (C) and zero (Z) flags.
// Accepts one command at a time, runs it through the external ALU and
// writes the result back. Each command takes three cycles: IDLE, EXEC, DONE.
//
// Optional build macro: ALU_SECUENCIADOR_CONTADOR_EN
//   defined   : ops_count counts completed legal ops and saturates at 0xFFFF
//   undefined : ops_count is tied to 0
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op                  ALU opcode; 0x0-0x9 are legal
//   cmd_ra/cmd_rb/cmd_rd    source and destination register indices
//   cmd_fin                 literal carry-in value
//   cmd_usec                carry-in select: 1 uses stored C, 0 uses cmd_fin
//   wr_en/wr_addr/wr_data   host register write port (active in any state)
//   rd_addr/rd_data         combinational host register read
//   ALUA/ALUB/ALUFlagIn/ALUControl   registered drive to the ALU
//   ALUResult/ALUFlags/ALUZero       ALU response
//   flag_c, flag_z          stored flags
//   done, err               one-cycle completion and illegal-op pulses
//   ops_count               completed legal op counter (see macro)
module alu_secuenciador #(
  parameter int ANCHO = 4,
  parameter int NREG  = 4,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [RW-1:0]    cmd_ra,
  input  logic [RW-1:0]    cmd_rb,
  input  logic [RW-1:0]    cmd_rd,
  input  logic             cmd_fin,
  input  logic             cmd_usec,
  input  logic             wr_en,
  input  logic [RW-1:0]    wr_addr,
  input  logic [ANCHO-1:0] wr_data,
  input  logic [RW-1:0]    rd_addr,
  output logic [ANCHO-1:0] rd_data,
  output logic [ANCHO-1:0] ALUA,
  output logic [ANCHO-1:0] ALUB,
  output logic             ALUFlagIn,
  output logic [3:0]       ALUControl,
  input  logic [ANCHO-1:0] ALUResult,
  input  logic             ALUFlags,
  input  logic             ALUZero,
  output logic             flag_c,
  output logic             flag_z,
  output logic             done,
  output logic             err,
  output logic [15:0]      ops_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [ANCHO-1:0] regs [NREG];
  logic [ANCHO-1:0] a_q;
  logic [ANCHO-1:0] b_q;
  logic [3:0]       op_q;
  logic [RW-1:0]    rd_q;
  logic             fin_q;
  logic             c_q;
  logic             z_q;
  logic             done_q;
  logic             err_q;
  logic             op_legal;

  assign op_legal = (op_q <= 4'd9);

  // The ALU only ever sees the latched operands, so nothing on cmd_* can
  // reach it combinationally. The latches also hold across DONE and IDLE.
  assign ALUA       = a_q;
  assign ALUB       = b_q;
  assign ALUFlagIn  = fin_q;
  assign ALUControl = op_q;

  assign cmd_ready = (state == ST_IDLE);
  assign rd_data   = regs[rd_addr];
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      fin_q  <= 1'b0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      // The host write comes first so that a write-back to the same index
      // later in this block overrides it.
      if (wr_en) begin
        regs[wr_addr] <= wr_data;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Operands are read before any host write on this edge lands.
            a_q   <= regs[cmd_ra];
            b_q   <= regs[cmd_rb];
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            fin_q <= cmd_usec ? c_q : cmd_fin;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_legal) begin
            regs[rd_q] <= ALUResult;
            c_q        <= ALUFlags;
            z_q        <= ALUZero;
          end
          done_q <= 1'b1;
          err_q  <= !op_legal;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SECUENCIADOR_CONTADOR_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_q <= '0;
    end else if (state == ST_EXEC && op_legal && ops_q != 16'hFFFF) begin
      ops_q <= ops_q + 16'd1;
    end
  end

  assign ops_count = ops_q;
`else
  assign ops_count = 16'h0000;
`endif

endmodule
